decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//  Registered RV32I(+M) decode/control stage between fetch and EX. Decodes one instruction per
//  accepted transfer into the EX/MEM/WB control bundle, inserts a load-use bubble, holds issue
//  for multi-cycle M-extension ops, and flags illegal encodings. Ready/valid on both sides.
// PARAMETERS
//  XLEN         32  width of in_pc / out_pc
//  ENABLE_MEXT  1   1: decode MUL/DIV family; 0: those encodings are illegal
//  MUL_LAT      3   EX cycles for mul/mulh/mulhsu/mulhu (>=1)
//  DIV_LAT      8   EX cycles for div/divu/rem/remu (>=1)
// PORTS
//  clk               in   1     clock
//  reset             in   1     synchronous, active-high
//  flush             in   1     sync kill of held output and pending state (branch/jump redirect)
//  in_valid/in_ready in/out 1   upstream handshake; transfer when both high
//  in_instr          in   32    instruction word
//  in_pc             in   XLEN  instruction PC
//  out_valid/out_ready out/in 1 downstream handshake
//  out_pc            out  XLEN  registered PC
//  out_rd/rs1/rs2    out  5     register fields
//  out_aluc          out  5     ALU op
//  out_aluOut_WB_memOut, out_rs1Data_EX_PC, out_write_reg, out_write_mem, out_read_mem  out 1
//  out_rs2Data_EX_imm64_4, out_pcImm_NEXTPC_rs1Imm  out 2;  out_extOP  out 3
//  out_mem_size      out  2     00 byte, 01 half, 10 word;  out_mem_unsigned out 1
//  out_bubble        out  1     inserted NOP;  out_illegal out 1  unsupported encoding
// BEHAVIOUR
//  Reset/flush: every out_* = 0, out_valid=0, ld_rd_q=0, state=RUN, cnt=0. Flush beats accept.
//  Decode (combinational, fully defaulted to 0, no latches):
//   lui/auipc: wr=1, src2=01, ext=001, aluc=0, src1=0/1. jal: wr, src1=1, src2=10, nxt=01, ext=100.
//   jalr: wr, src1=1, src2=11, aluc=01010, nxt=10, ext=000. branch: ext=011, aluc beq..bgeu=11..16
//   (func3 000,001,100,101,110,111). load: wr, wbsel=1, src2=01, read_mem=1, func3 000/001/010/100/101.
//   store: src2=01, ext=010, write_mem=1, func3 000/001/010. mem_size=func3[1:0], unsigned=func3[2].
//   OP-IMM/OP: add0 sub1 and2 or3 xor4 sll5 slt6 sltu7 srl8 sra9; srai ext=101; OP ext=111.
//   M (func7=0000001, ENABLE_MEXT): mul..remu = 17..24 by func3.
//   Anything else (opcode, func3, func7 not in {0000000, 0100000 for sub/sra/srai, M}): all
//   side-effect controls (wr, write_mem, read_mem, nxt) 0, out_illegal=1, still transferred.
//  Load register ld_rd_q: on each accept = rd if load and rd!=0, else 0.
//  hazard = in_valid & ld_rd_q!=0 & (ld_rd_q==rs1 | ld_rd_q==rs2 for formats using them).
//  slot_free = !out_valid | out_ready.
//  RUN: in_ready = slot_free & !hazard & !flush. Accept loads out_* next edge, out_valid=1.
//   hazard & slot_free: load bubble (all controls 0, out_bubble=1, out_valid=1), ld_rd_q=0;
//   instruction accepted on a later cycle. Exactly one bubble per load-use pair.
//   Accept of M op with LAT>1: state->MBUSY, cnt=LAT-1 (MUL_LAT or DIV_LAT).
//  MBUSY: in_ready=0; cnt decrements every cycle regardless of out_ready; cnt==1 -> RUN next edge.
//  Output held stable while out_valid & !out_ready. No transfer -> out_valid cleared on out_ready.
//  Latency: accept at edge N -> out_valid at N+1. Throughput 1/cycle with no hazards.
// TESTING
//  1 add x3,x1,x2 then addi x4,x3,5, out_ready=1 -> two beats, aluc 0/0, src2 00/01, no bubble.
//  2 lw x5,0(x1) then add x6,x5,x2 -> beats: lw(read_mem=1,size=10), bubble=1, add; in_ready low 1 cyc.
//  3 lb x5 then lbu x7 -> size 00 unsigned 0, then size 00 unsigned 1; lw to x0 then use x0 -> no bubble.
//  4 mul x8,x1,x2 (MUL_LAT=3) then add -> in_ready 0 for 2 cycles after mul accept; ENABLE_MEXT=0 -> illegal=1.
//  5 out_ready=0 for 4 cycles holding beq -> outputs stable, aluc=01011, in_ready 0; then drains.
//  6 flush during MBUSY with div pending and in_valid=1 -> out_valid=0 next, state RUN, no accept that cycle.

Source files
------------

// File: rtl/decode_ctrl_pipe_if.sv
// Purpose: fetch->decode and decode->EX handshake plus the EX/MEM/WB control bundle.
// Latency: none (wiring only).
// Backpressure: in_ready / out_ready ready-valid on each side.
// Ports: slave = decode stage side, master = producer/consumer side (fetch + EX).
interface decode_ctrl_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_aluc;
  logic            out_aluOut_WB_memOut;
  logic            out_rs1Data_EX_PC;
  logic            out_write_reg;
  logic            out_write_mem;
  logic            out_read_mem;
  logic [1:0]      out_rs2Data_EX_imm64_4;
  logic [1:0]      out_pcImm_NEXTPC_rs1Imm;
  logic [2:0]      out_extOP;
  logic [1:0]      out_mem_size;
  logic            out_mem_unsigned;
  logic            out_bubble;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_aluc,
           out_aluOut_WB_memOut, out_rs1Data_EX_PC, out_write_reg, out_write_mem,
           out_read_mem, out_rs2Data_EX_imm64_4, out_pcImm_NEXTPC_rs1Imm, out_extOP,
           out_mem_size, out_mem_unsigned, out_bubble, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_aluc,
           out_aluOut_WB_memOut, out_rs1Data_EX_PC, out_write_reg, out_write_mem,
           out_read_mem, out_rs2Data_EX_imm64_4, out_pcImm_NEXTPC_rs1Imm, out_extOP,
           out_mem_size, out_mem_unsigned, out_bubble, out_illegal
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Purpose: registered RV32I(+M) decode/control stage between fetch and EX.
// Latency: accept at edge N -> out_valid after N; one bubble per load-use pair.
// Backpressure: in_ready low while output held, on load-use hazard, flush, or multi-cycle M op.
// Ports: clk; reset (sync, active-high); flush (kills held beat and pending state);
//        io (slave): in_valid/in_ready/in_instr/in_pc upstream, out_valid/out_ready + control bundle.
module decode_ctrl_pipe #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_MEXT = 1'b1,
  parameter int MUL_LAT     = 3,
  parameter int DIV_LAT     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  decode_ctrl_pipe_if.slave io
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011,
                         OPC_ST = 7'b0100011, OPC_IMM = 7'b0010011, OPC_OP = 7'b0110011;

  typedef enum logic {RUN, MBUSY} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd, rs1, rs2, aluc;
    logic            wbsel, src1, wr, wmem, rmem;
    logic [1:0]      src2, nxt;
    logic [2:0]      ext;
    logic [1:0]      msize;
    logic            munsigned, bubble, illegal;
  } ctrl_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [4:0]         ld_rd_q, ld_rd_d;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = io.in_instr[6:0];
  assign rd     = io.in_instr[11:7];
  assign f3     = io.in_instr[14:12];
  assign rs1    = io.in_instr[19:15];
  assign rs2    = io.in_instr[24:20];
  assign f7     = io.in_instr[31:25];

  ctrl_t dec;
  logic  illegal, is_load, is_m, is_div, use_rs1, use_rs2;

  always_comb begin
    dec = '0;
    illegal = 1'b0;
    is_load = 1'b0;
    is_m    = 1'b0;
    is_div  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec.wr = 1'b1; dec.src2 = 2'b01; dec.ext = 3'b001;
        dec.src1 = (opcode == OPC_AUIPC);
      end
      OPC_JAL: begin
        dec.wr = 1'b1; dec.src1 = 1'b1; dec.src2 = 2'b10; dec.nxt = 2'b01; dec.ext = 3'b100;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1;
        if (f3 != 3'b000) illegal = 1'b1;
        dec.wr = 1'b1; dec.src1 = 1'b1; dec.src2 = 2'b11; dec.aluc = 5'd10; dec.nxt = 2'b10;
      end
      OPC_BR: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.ext = 3'b011;
        case (f3)
          3'b000: dec.aluc = 5'd11;
          3'b001: dec.aluc = 5'd12;
          3'b100: dec.aluc = 5'd13;
          3'b101: dec.aluc = 5'd14;
          3'b110: dec.aluc = 5'd15;
          3'b111: dec.aluc = 5'd16;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LD: begin
        use_rs1 = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal = 1'b1;
        dec.wr = 1'b1; dec.wbsel = 1'b1; dec.src2 = 2'b01; dec.rmem = 1'b1; is_load = 1'b1;
        dec.msize = f3[1:0]; dec.munsigned = f3[2];
      end
      OPC_ST: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f3[2] || f3[1:0] == 2'b11) illegal = 1'b1;
        dec.src2 = 2'b01; dec.ext = 3'b010; dec.wmem = 1'b1;
        dec.msize = f3[1:0]; dec.munsigned = f3[2];
      end
      OPC_IMM: begin
        use_rs1 = 1'b1; dec.wr = 1'b1; dec.src2 = 2'b01;
        case (f3)
          3'b000: dec.aluc = 5'd0;
          3'b010: dec.aluc = 5'd6;
          3'b011: dec.aluc = 5'd7;
          3'b100: dec.aluc = 5'd4;
          3'b110: dec.aluc = 5'd3;
          3'b111: dec.aluc = 5'd2;
          3'b001: begin dec.aluc = 5'd5; illegal = (f7 != 7'b0000000); end
          default: begin // 3'b101: srli / srai share func3, split on func7
            if (f7 == 7'b0000000)      dec.aluc = 5'd8;
            else if (f7 == 7'b0100000) begin dec.aluc = 5'd9; dec.ext = 3'b101; end
            else                       illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.wr = 1'b1; dec.ext = 3'b111;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: dec.aluc = 5'd0;
            3'b001: dec.aluc = 5'd5;
            3'b010: dec.aluc = 5'd6;
            3'b011: dec.aluc = 5'd7;
            3'b100: dec.aluc = 5'd4;
            3'b101: dec.aluc = 5'd8;
            3'b110: dec.aluc = 5'd3;
            default: dec.aluc = 5'd2;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.aluc = 5'd1;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.aluc = 5'd9;
        end else if (f7 == 7'b0000001 && ENABLE_MEXT) begin
          dec.aluc = 5'd17 + {2'b00, f3};
          is_m = 1'b1; is_div = f3[2];
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    // Illegal words still flow to EX (for the trap path) but must not touch state.
    if (illegal) begin
      dec = '0;
      is_load = 1'b0;
      is_m = 1'b0;
    end
    dec.illegal = illegal;
    dec.pc  = io.in_pc;
    dec.rd  = rd;
    dec.rs1 = rs1;
    dec.rs2 = rs2;
  end

  logic hazard, slot_free, in_ready_c, accept;
  assign hazard = io.in_valid && (ld_rd_q != 5'd0) &&
                  ((use_rs1 && ld_rd_q == rs1) || (use_rs2 && ld_rd_q == rs2));
  assign slot_free = !out_valid_q || io.out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ld_rd_d     = ld_rd_q;
    in_ready_c  = (state_q == RUN) && slot_free && !hazard && !flush;
    accept      = in_ready_c && io.in_valid;

    if (io.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
      ld_rd_d     = (is_load && rd != 5'd0) ? rd : 5'd0;
      if (is_m && is_div && DIV_LAT > 1) begin
        state_d = MBUSY; cnt_d = CNT_W'(DIV_LAT - 1);
      end else if (is_m && !is_div && MUL_LAT > 1) begin
        state_d = MBUSY; cnt_d = CNT_W'(MUL_LAT - 1);
      end
    end else if (state_q == RUN && hazard && slot_free) begin
      // Clearing ld_rd_q guarantees the stalled consumer issues next cycle.
      out_d        = '0;
      out_d.bubble = 1'b1;
      out_valid_d  = 1'b1;
      ld_rd_d      = 5'd0;
    end

    // M-op counter runs independent of downstream backpressure.
    if (state_q == MBUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) state_d = RUN;
    end

    if (flush) begin
      state_d     = RUN;
      cnt_d       = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
      ld_rd_d     = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ld_rd_q     <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ld_rd_q     <= ld_rd_d;
    end
  end

  assign io.in_ready                = in_ready_c;
  assign io.out_valid               = out_valid_q;
  assign io.out_pc                  = out_q.pc;
  assign io.out_rd                  = out_q.rd;
  assign io.out_rs1                 = out_q.rs1;
  assign io.out_rs2                 = out_q.rs2;
  assign io.out_aluc                = out_q.aluc;
  assign io.out_aluOut_WB_memOut    = out_q.wbsel;
  assign io.out_rs1Data_EX_PC       = out_q.src1;
  assign io.out_write_reg           = out_q.wr;
  assign io.out_write_mem           = out_q.wmem;
  assign io.out_read_mem            = out_q.rmem;
  assign io.out_rs2Data_EX_imm64_4  = out_q.src2;
  assign io.out_pcImm_NEXTPC_rs1Imm = out_q.nxt;
  assign io.out_extOP               = out_q.ext;
  assign io.out_mem_size            = out_q.msize;
  assign io.out_mem_unsigned        = out_q.munsigned;
  assign io.out_bubble              = out_q.bubble;
  assign io.out_illegal             = out_q.illegal;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Purpose: scoreboard bench for decode_ctrl_pipe (directed RV32I/M vectors).
// Latency: expected beats queued at issue, checked when the DUT presents a transfer.
// Backpressure: out_ready driven per test to exercise hold, hazard and flush paths.
module tb_decode_ctrl_pipe;
  localparam logic [6:0] OP = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                         BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                         LUI = 7'b0110111, AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2, aluc;
    logic        wbsel, src1, wr, wmem, rmem;
    logic [1:0]  src2, nxt;
    logic [2:0]  ext;
    logic [1:0]  msize;
    logic        munsigned, bubble, illegal;
  } beat_t;

  logic clk = 1'b0;
  logic reset, flush, flush2;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.XLEN(32)) io();
  decode_ctrl_pipe_if #(.XLEN(32)) io2();

  decode_ctrl_pipe #(.XLEN(32), .ENABLE_MEXT(1'b1), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .io(io.slave));
  decode_ctrl_pipe #(.XLEN(32), .ENABLE_MEXT(1'b0), .MUL_LAT(3), .DIV_LAT(8)) dut_nom (
    .clk(clk), .reset(reset), .flush(flush2), .io(io2.slave));

  beat_t act, act2;
  assign act = {io.out_pc, io.out_rd, io.out_rs1, io.out_rs2, io.out_aluc,
                io.out_aluOut_WB_memOut, io.out_rs1Data_EX_PC, io.out_write_reg,
                io.out_write_mem, io.out_read_mem, io.out_rs2Data_EX_imm64_4,
                io.out_pcImm_NEXTPC_rs1Imm, io.out_extOP, io.out_mem_size,
                io.out_mem_unsigned, io.out_bubble, io.out_illegal};
  assign act2 = {io2.out_pc, io2.out_rd, io2.out_rs1, io2.out_rs2, io2.out_aluc,
                 io2.out_aluOut_WB_memOut, io2.out_rs1Data_EX_PC, io2.out_write_reg,
                 io2.out_write_mem, io2.out_read_mem, io2.out_rs2Data_EX_imm64_4,
                 io2.out_pcImm_NEXTPC_rs1Imm, io2.out_extOP, io2.out_mem_size,
                 io2.out_mem_unsigned, io2.out_bubble, io2.out_illegal};

  int tests = 0;
  int fails = 0;
  logic [31:0] pc;
  beat_t sb[$];
  string sb_name[$];

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic beat_t mk(input logic [4:0] rd, rs1, rs2, aluc, input logic [2:0] ext,
                               input logic [1:0] src2, input logic wr);
    beat_t b;
    b = '0;
    b.pc = pc; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.aluc = aluc;
    b.ext = ext; b.src2 = src2; b.wr = wr;
    return b;
  endfunction

  task automatic chk_beat(input string name, input beat_t got, input beat_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Monitor: every downstream transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && io.out_valid && io.out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h required no beat", act);
      end else begin
        beat_t e;
        string n;
        e = sb.pop_front();
        n = sb_name.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL %s: got %h required %h", n, act, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    io.in_valid = 1'b1;
    io.in_instr = instr;
    io.in_pc    = pc;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (io.in_ready) acc = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept required accept for %h", instr);
    end
  endtask

  task automatic issue(input string name, input logic [31:0] instr, input beat_t e,
                       output int stalls);
    sb.push_back(e);
    sb_name.push_back(name);
    send(instr, stalls);
    pc = pc + 32'd4;
  endtask

  task automatic push_bubble(input string name);
    beat_t b;
    b = '0;
    b.bubble = 1'b1;
    sb.push_back(b);
    sb_name.push_back(name);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t e, beq_e;
    int st;
    reset = 1'b1; flush = 1'b0; flush2 = 1'b0; pc = 32'h100;
    io.in_valid = 1'b0; io.in_instr = '0; io.in_pc = '0; io.out_ready = 1'b1;
    io2.in_valid = 1'b0; io2.in_instr = '0; io2.in_pc = '0; io2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk_beat("reset_bundle", act, '0);
    chk_int("reset_out_valid", int'(io.out_valid), 0);
    chk_int("reset_in_ready", int'(io.in_ready), 1);
    idle();

    // Basic ALU / immediate / control-flow encodings.
    e = mk(3, 1, 2, 0, 3'b111, 2'b00, 1);   issue("add", rtype(0, 2, 1, 3'b000, 3, OP), e, st);
    e = mk(4, 3, 5, 0, 3'b000, 2'b01, 1);   issue("addi", itype(12'd5, 3, 3'b000, 4, IMM), e, st);
    chk_int("addi_no_stall", st, 0);
    e = mk(11, 1, 2, 1, 3'b111, 2'b00, 1);  issue("sub", rtype(7'b0100000, 2, 1, 3'b000, 11, OP), e, st);
    e = mk(12, 1, 3, 9, 3'b101, 2'b01, 1);
    issue("srai", itype({7'b0100000, 5'd3}, 1, 3'b101, 12, IMM), e, st);
    e = mk(1, 0, 0, 0, 3'b100, 2'b10, 1); e.src1 = 1'b1; e.nxt = 2'b01;
    issue("jal", {20'h0, 5'd1, JAL}, e, st);
    e = mk(1, 5, 0, 10, 3'b000, 2'b11, 1); e.src1 = 1'b1; e.nxt = 2'b10;
    issue("jalr", itype(12'd0, 5, 3'b000, 1, JALR), e, st);
    e = mk(13, 0, 0, 0, 3'b001, 2'b01, 1);  issue("lui", {20'h0, 5'd13, LUI}, e, st);
    e = mk(13, 0, 0, 0, 3'b001, 2'b01, 1); e.src1 = 1'b1;
    issue("auipc", {20'h0, 5'd13, AUIPC}, e, st);
    e = mk(4, 1, 2, 0, 3'b010, 2'b01, 0); e.wmem = 1'b1; e.msize = 2'b10;
    issue("sw", {7'b0, 5'd2, 5'd1, 3'b010, 5'd4, ST}, e, st);
    e = mk(3, 1, 2, 0, 3'b000, 2'b00, 0); e.illegal = 1'b1;
    issue("bad_opcode", {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b1111111}, e, st);
    e = mk(3, 1, 2, 0, 3'b000, 2'b00, 0); e.illegal = 1'b1;
    issue("bad_func7", rtype(7'b0100000, 2, 1, 3'b001, 3, OP), e, st);

    // Load-use: lw x5 then add x6,x5,x2 -> exactly one bubble.
    e = mk(5, 1, 0, 0, 3'b000, 2'b01, 1); e.wbsel = 1'b1; e.rmem = 1'b1; e.msize = 2'b10;
    issue("lw", itype(12'd0, 1, 3'b010, 5, LD), e, st);
    push_bubble("lw_bubble");
    e = mk(6, 5, 2, 0, 3'b111, 2'b00, 1);   issue("add_after_lw", rtype(0, 2, 5, 3'b000, 6, OP), e, st);
    chk_int("load_use_stall", st, 1);

    // Byte loads, signed vs unsigned; load to x0 never stalls a consumer of x0.
    e = mk(5, 1, 0, 0, 3'b000, 2'b01, 1); e.wbsel = 1'b1; e.rmem = 1'b1;
    issue("lb", itype(12'd0, 1, 3'b000, 5, LD), e, st);
    e = mk(7, 1, 0, 0, 3'b000, 2'b01, 1); e.wbsel = 1'b1; e.rmem = 1'b1; e.munsigned = 1'b1;
    issue("lbu", itype(12'd0, 1, 3'b100, 7, LD), e, st);
    e = mk(0, 1, 0, 0, 3'b000, 2'b01, 1); e.wbsel = 1'b1; e.rmem = 1'b1; e.msize = 2'b10;
    issue("lw_x0", itype(12'd0, 1, 3'b010, 0, LD), e, st);
    e = mk(9, 0, 0, 0, 3'b111, 2'b00, 1);   issue("add_x0", rtype(0, 0, 0, 3'b000, 9, OP), e, st);
    chk_int("x0_no_stall", st, 0);

    // Multi-cycle multiply holds issue for MUL_LAT-1 cycles.
    e = mk(8, 1, 2, 17, 3'b111, 2'b00, 1);  issue("mul", rtype(7'b0000001, 2, 1, 3'b000, 8, OP), e, st);
    e = mk(10, 1, 2, 0, 3'b111, 2'b00, 1);  issue("add_after_mul", rtype(0, 2, 1, 3'b000, 10, OP), e, st);
    chk_int("mul_stall", st, 2);

    // M extension disabled: mul decodes as illegal with no side effects.
    io2.in_valid = 1'b1; io2.in_pc = 32'h400;
    io2.in_instr = rtype(7'b0000001, 2, 1, 3'b000, 8, OP);
    @(negedge clk);
    chk_int("nom_in_ready", int'(io2.in_ready), 1);
    @(posedge clk); #1 io2.in_valid = 1'b0;
    @(negedge clk);
    e = '0; e.pc = 32'h400; e.rd = 5'd8; e.rs1 = 5'd1; e.rs2 = 5'd2; e.illegal = 1'b1;
    chk_int("nom_out_valid", int'(io2.out_valid), 1);
    chk_beat("nom_mul_illegal", act2, e);

    // Downstream stall: beq held stable for 4 cycles, upstream blocked.
    idle();
    io.out_ready = 1'b0;
    beq_e = mk(0, 1, 2, 11, 3'b011, 2'b00, 0);
    issue("beq", {7'b0, 5'd2, 5'd1, 3'b000, 5'd0, BR}, beq_e, st);
    io.in_valid = 1'b1; io.in_instr = itype(12'd5, 3, 3'b000, 4, IMM); io.in_pc = pc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_beat("hold_beq", act, beq_e);
      chk_int("hold_out_valid", int'(io.out_valid), 1);
      chk_int("hold_in_ready", int'(io.in_ready), 0);
      @(posedge clk); #1;
    end
    io.out_ready = 1'b1;
    e = mk(4, 3, 5, 0, 3'b000, 2'b01, 1);   issue("addi_after_hold", itype(12'd5, 3, 3'b000, 4, IMM), e, st);

    // Flush while a divide is in flight and its beat is held downstream.
    idle();
    io.out_ready = 1'b0;
    send(rtype(7'b0000001, 2, 1, 3'b100, 14, OP), st);
    pc = pc + 32'd4;
    io.in_valid = 1'b1; io.in_instr = rtype(0, 2, 1, 3'b000, 15, OP); io.in_pc = pc;
    @(negedge clk);
    chk_int("div_busy_in_ready", int'(io.in_ready), 0);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk_int("flush_no_accept", int'(io.in_ready), 0);
    @(posedge clk); #1 flush = 1'b0; io.out_ready = 1'b1;
    @(negedge clk);
    chk_int("flush_out_valid", int'(io.out_valid), 0);
    chk_int("flush_state_run", int'(io.in_ready), 1);
    e = mk(15, 1, 2, 0, 3'b111, 2'b00, 1);  issue("add_after_flush", rtype(0, 2, 1, 3'b000, 15, OP), e, st);
    chk_int("after_flush_stall", st, 0);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    chk_int("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
